// File: rtl/div_clk_monitor.sv
// Divide-by-3 output monitor: period/high-time measurement, lock, timeout.
// Optional DIV_MON_DUTY_CHECK_EN adds the high-time check to the match.
module div_clk_monitor #(
  parameter int unsigned CW         = 8,
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned EXP_HIGH   = 2,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          div_in,
  output logic [CW-1:0] meas_period,
  output logic [CW-1:0] meas_high,
  output logic          meas_valid,
  output logic          mismatch,
  output logic          locked,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TRACK
  } state_t;

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] EXP_P = CW'(EXP_PERIOD);
  localparam logic [CW-1:0] EXP_H = CW'(EXP_HIGH);
  localparam logic [3:0]    LOCK_N = 4'(LOCK_COUNT);

`ifdef DIV_MON_DUTY_CHECK_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic          s0;
  logic          s1;
  logic          rise;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hcnt;
  logic [3:0]    match_cnt;
  logic [CW-1:0] period_nx;
  logic          match_nx;
  logic          capture;
  logic          expire;
  state_t        state;
  state_t        state_nx;

  assign rise = s0 & ~s1;

  assign period_nx = (cnt == CMAX) ? CMAX : cnt + CW'(1);

  assign match_nx = (period_nx == EXP_P) &
                    (~DUTY_EN | (hcnt == EXP_H));

  // Expire on the edge where cnt would reach all-ones, so a rise in
  // that same cycle still closes a valid (maximum-length) period.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nx = MEASURE;
      end
      MEASURE, TRACK: begin
        if (rise) begin
          capture  = 1'b1;
          state_nx = TRACK;
        end else if (cnt == CMAX - CW'(1)) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      cnt         <= '0;
      hcnt        <= '0;
      match_cnt   <= '0;
      state       <= IDLE;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      mismatch    <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      s0    <= div_in;
      s1    <= s0;
      state <= state_nx;

      if (rise) begin
        cnt  <= '0;
        hcnt <= CW'(1);
      end else begin
        if (cnt != CMAX) cnt <= cnt + CW'(1);
        if (s0 && hcnt != CMAX) hcnt <= hcnt + CW'(1);
      end

      meas_valid <= capture;
      mismatch   <= capture & ~match_nx;
      timeout    <= expire;

      if (capture) begin
        meas_period <= period_nx;
        meas_high   <= hcnt;
      end

      // Lock bookkeeping runs off the registered result pulse.
      if (expire) begin
        locked    <= 1'b0;
        match_cnt <= '0;
      end else if (meas_valid) begin
        if (mismatch) begin
          locked    <= 1'b0;
          match_cnt <= '0;
        end else begin
          if (match_cnt != LOCK_N) match_cnt <= match_cnt + 4'd1;
          locked <= ({1'b0, match_cnt} + 5'd1) >= {1'b0, LOCK_N};
        end
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Randomized bench for div_clk_monitor with a history-based reference model.
module tb_div_clk_monitor;

  localparam int CW = 8;
  localparam int EP = 3;
  localparam int EH = 2;
  localparam int LC = 4;

`ifdef DIV_MON_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          div_in = 1'b0;
  logic [CW-1:0] meas_period;
  logic [CW-1:0] meas_high;
  logic          meas_valid;
  logic          mismatch;
  logic          locked;
  logic          timeout;

  div_clk_monitor #(
    .CW(CW), .EXP_PERIOD(EP), .EXP_HIGH(EH), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .div_in(div_in),
    .meas_period(meas_period),
    .meas_high(meas_high),
    .meas_valid(meas_valid),
    .mismatch(mismatch),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: rise times and high counts come from the sampled
  // history; lock is a run-length of good periods.
  bit   hist[$];
  int   last_rise = -1;
  bit   armed = 0;
  int   run = 0;
  bit   pend = 0;
  bit   pend_val = 0;
  bit   started = 0;
  int   e_per = 0;
  int   e_high = 0;
  bit   e_mv = 0;
  bit   e_mm = 0;
  bit   e_lk = 0;
  bit   e_to = 0;

  always @(posedge clk) begin : model
    int n;
    int ones;
    bit r;
    bit good;
    cyc++;
    if (reset) begin
      started = 1;
      armed = 0;
      last_rise = -1;
      run = 0;
      pend = 0;
      e_per = 0; e_high = 0;
      e_mv = 0; e_mm = 0; e_lk = 0; e_to = 0;
      hist.push_back(1'b0);
    end else begin
      n = hist.size() - 1;
      r = hist[n] && (n == 0 || !hist[n-1]);
      e_mv = 0; e_mm = 0; e_to = 0;
      if (pend) begin
        e_lk = pend_val;
        pend = 0;
      end
      if (r) begin
        if (armed) begin
          ones = 0;
          for (int k = last_rise; k < n; k++) ones += int'(hist[k]);
          e_per = n - last_rise;
          e_high = ones;
          good = (e_per == EP) && (!DUTY || ones == EH);
          e_mv = 1;
          pend = 1;
          if (good) begin
            if (run < LC) run++;
            pend_val = (run >= LC);
          end else begin
            e_mm = 1;
            run = 0;
            pend_val = 0;
          end
        end
        armed = 1;
        last_rise = n;
      end else if (armed && n - last_rise == 255) begin
        e_to = 1;
        e_lk = 0;
        run = 0;
        armed = 0;
      end
      hist.push_back(div_in);
    end
  end

  int mv_cnt = 0;
  int mm_cnt = 0;
  int to_cnt = 0;
  int first_mv = -1;
  int lock_cyc = -1;
  int to_cyc = -1;
  int mm_per = -1;
  bit seen255 = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("meas_period", int'(meas_period), e_per);
      chk("meas_high", int'(meas_high), e_high);
      chk("meas_valid", int'(meas_valid), int'(e_mv));
      chk("mismatch", int'(mismatch), int'(e_mm));
      chk("locked", int'(locked), int'(e_lk));
      chk("timeout", int'(timeout), int'(e_to));
      if (meas_valid) begin
        mv_cnt++;
        if (first_mv < 0) first_mv = cyc;
        if (meas_period == 8'd255) seen255 = 1;
      end
      if (mismatch) begin
        mm_cnt++;
        mm_per = int'(meas_period);
      end
      if (timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (locked && lock_cyc < 0) lock_cyc = cyc;
    end
  end

  task automatic step(input bit v);
    @(negedge clk);
    div_in = v;
  endtask

  task automatic per(input int L, input int H);
    for (int i = 0; i < L; i++) step(i < H);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    div_in = 1'b0;
    @(negedge clk);
    chk("rst_period", int'(meas_period), 0);
    chk("rst_high", int'(meas_high), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
  endtask

  int r0;
  int q0;
  int kind;
  int len;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    per(5, 0);

    // clean divide-by-3 from reset
    first_mv = -1; lock_cyc = -1; mm_cnt = 0;
    @(negedge clk);
    r0 = cyc;
    div_in = 1'b1;
    step(1); step(0);
    repeat (5) per(3, 2);
    chk("clean_first_valid", first_mv, r0 + 5);
    chk("clean_lock_cycle", lock_cyc, r0 + 15);
    chk("clean_no_mismatch", mm_cnt, 0);
    chk("clean_period", int'(meas_period), 3);
    chk("clean_high", int'(meas_high), 2);

    // one stretched period, then relock
    mm_cnt = 0;
    per(4, 2);
    repeat (6) per(3, 2);
    chk("stretch_mismatch_count", mm_cnt, 1);
    chk("stretch_period", mm_per, 4);
    chk("stretch_relock", int'(locked), 1);

    // wrong duty cycle
    mm_cnt = 0;
    repeat (8) per(3, 1);
    chk("duty_high", int'(meas_high), 1);
    chk("duty_locked", int'(locked), DUTY ? 0 : 1);
    chk("duty_mismatches", mm_cnt, DUTY ? 7 : 0);

    // stuck low after lock
    repeat (6) per(3, 2);
    chk("pre_timeout_locked", int'(locked), 1);
    @(negedge clk);
    q0 = cyc;
    div_in = 1'b1;
    step(1); step(0);
    to_cnt = 0;
    per(300, 0);
    chk("timeout_count", to_cnt, 1);
    chk("timeout_cycle", to_cyc, q0 + 257);
    chk("timeout_unlocked", int'(locked), 0);
    mv_cnt = 0;
    repeat (4) per(3, 2);
    per(2, 0);
    chk("rearm_valid_count", mv_cnt, 3);

    // reset mid-period while locked
    repeat (6) per(3, 2);
    chk("pre_reset_locked", int'(locked), 1);
    step(1);
    do_reset();
    first_mv = -1;
    @(negedge clk);
    r0 = cyc;
    div_in = 1'b1;
    step(1); step(0);
    repeat (2) per(3, 2);
    chk("reset_first_valid", first_mv, r0 + 5);

    // longest valid period, then one cycle too long
    to_cnt = 0; seen255 = 0;
    repeat (2) per(3, 2);
    per(255, 1);
    repeat (2) per(3, 2);
    chk("max_period_seen", int'(seen255), 1);
    chk("max_period_no_timeout", to_cnt, 0);
    per(256, 1);
    per(3, 2);
    chk("over_period_timeout", to_cnt, 1);

    // randomized segments
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        0: repeat ($urandom_range(1, 8)) per(3, 2);
        1: per(4, 2);
        2: per(3, 1);
        3: begin
          len = int'($urandom_range(1, 10));
          per(len, int'($urandom_range(0, len)));
        end
        4: per(int'($urandom_range(250, 260)), 1);
        5: begin
          len = int'($urandom_range(260, 300));
          per(len, len);
        end
        default: begin
          step(1);
          do_reset();
        end
      endcase
    end
    per(10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
